aes_key_sched: RTL and testbench

- AES-128 round-key generator that feeds the AddRoundKey step following the tiled SubBytes/ShiftRows/MixColumns unit.
- Accepts a 128-bit cipher key and emits the 11 round keys one at a time over a valid/ready handshake.
  - Encrypt order: 0..10.
  - Decrypt order: 10..0, by winding forward internally and then running the inverse key schedule.
- Uses four instances of the existing forward S-box (aes_fwd_sbox) for SubWord. One schedule step per cycle.

---
 rtl/aes_key_sched.sv | 199 +++++++++++++++++++
 tb/tb_aes_key_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// AES-128 round-key generator. Emits round keys 0..10 (encrypt) or 10..0
// (decrypt) over a valid/ready handshake, one schedule step per cycle.
// Decrypt winds forward to round 10 first, then runs the inverse schedule.
//
// Ports:
//   g_clk, g_reset      : clock, synchronous active-high reset
//   key_valid/key_ready : cipher key handshake (key_in, dec sampled on accept)
//   key_in[127:0]       : cipher key, w0 in [127:96], FIPS byte 0 is MSB
//   dec                 : 1 = emit keys in descending order
//   flush               : abandon current key, return to idle
//   rk_valid/rk_ready   : round-key handshake
//   rk[127:0], rk_idx   : round key and its round number
//   rk_last             : final key of the sequence

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_fwd_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ b;
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_sched #(
    parameter bit DECRYPT_EN = 1'b1
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         dec,
    input  logic         flush,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);
    localparam int unsigned WW = 32;
    localparam logic [3:0] LAST_IDX = 4'd10;
    localparam logic [3:0] WIND_END = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIND = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state;
    state_t nxt;

    logic          dec_q;
    logic          dec_in;
    logic          accept;
    logic          hs;
    logic          step;
    logic          inv_step;
    logic [WW-1:0] w0, w1, w2, w3;
    logic [WW-1:0] i0, i1, i2, i3;
    logic [WW-1:0] f0, f1, f2, f3;
    logic [WW-1:0] sb_src;
    logic [WW-1:0] sb_in;
    logic [WW-1:0] sub_out;
    logic [WW-1:0] t;
    logic [3:0]    rcon_idx;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign dec_in   = DECRYPT_EN ? dec : 1'b0;
    assign accept   = (state == IDLE) && key_valid && !flush;
    assign hs       = rk_valid && rk_ready;
    assign inv_step = (state == EMIT) && dec_q;
    assign step     = !flush && ((state == WIND) || ((state == EMIT) && hs && !rk_last));

    assign w0 = rk[WW*3 +: WW];
    assign w1 = rk[WW*2 +: WW];
    assign w2 = rk[WW*1 +: WW];
    assign w3 = rk[WW*0 +: WW];

    // Inverse step recovers w3 of the previous round first; that word feeds SubWord.
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;

    // SubWord(RotWord(.)) shared by forward and inverse steps.
    assign sb_src   = inv_step ? i3 : w3;
    assign sb_in    = {sb_src[23:0], sb_src[31:24]};
    assign rcon_idx = inv_step ? rk_idx : rk_idx + 4'd1;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_fwd_sbox u_sbox (
            .a (sb_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    assign t  = sub_out ^ {rcon(rcon_idx), 24'h000000};
    assign i0 = w0 ^ t;
    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) state <= IDLE;
        else         state <= nxt;
    end

    // Next-state logic; flush overrides any handshake.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (key_valid) nxt = dec_in ? WIND : EMIT;
            WIND:    if (rk_idx == WIND_END) nxt = EMIT;
            EMIT:    if (hs && rk_last) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    // State-decoded handshake outputs.
    always_comb begin
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state)
            IDLE:    key_ready = 1'b1;
            EMIT:    rk_valid  = 1'b1;
            default: ;
        endcase
    end

    // Round-key datapath; rk_last is precomputed for the key being loaded.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rk      <= '0;
            rk_idx  <= '0;
            rk_last <= 1'b0;
            dec_q   <= 1'b0;
        end else if (accept) begin
            rk      <= key_in;
            rk_idx  <= '0;
            rk_last <= 1'b0;
            dec_q   <= dec_in;
        end else if (step) begin
            rk      <= inv_step ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
            rk_idx  <= inv_step ? rk_idx - 4'd1 : rk_idx + 4'd1;
            rk_last <= (state == EMIT) &&
                       (dec_q ? (rk_idx == 4'd1) : (rk_idx == LAST_IDX - 4'd1));
        end else if (flush) begin
            rk_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_key_sched.sv
// Testbench for aes_key_sched: directed FIPS-197 vectors, randomized keys and
// backpressure, flush, reset and a DECRYPT_EN=0 instance, checked against a
// FIPS-style key expansion model.
module tb_aes_key_sched;
    logic         g_clk = 1'b0;
    logic         g_reset = 1'b1;
    logic         kv = 1'b0;
    logic         sel = 1'b0;
    logic [127:0] key_in = '0;
    logic         dec = 1'b0;
    logic         flush = 1'b0;
    logic         rk_ready = 1'b0;

    logic         key_valid1, key_valid0;
    logic         key_ready1, key_ready0;
    logic         rk_valid1, rk_valid0;
    logic [127:0] rk1, rk0;
    logic [3:0]   rk_idx1, rk_idx0;
    logic         rk_last1, rk_last0;

    logic         c_kready, c_valid, c_last;
    logic [127:0] c_rk;
    logic [3:0]   c_idx;

    int checks = 0;
    int failures = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    assign key_valid1 = kv & ~sel;
    assign key_valid0 = kv & sel;
    assign c_kready = sel ? key_ready0 : key_ready1;
    assign c_valid  = sel ? rk_valid0  : rk_valid1;
    assign c_last   = sel ? rk_last0   : rk_last1;
    assign c_rk     = sel ? rk0        : rk1;
    assign c_idx    = sel ? rk_idx0    : rk_idx1;

    aes_key_sched #(.DECRYPT_EN(1'b1)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .key_valid(key_valid1), .key_ready(key_ready1),
        .key_in(key_in), .dec(dec), .flush(flush), .rk_valid(rk_valid1), .rk_ready(rk_ready),
        .rk(rk1), .rk_idx(rk_idx1), .rk_last(rk_last1)
    );

    aes_key_sched #(.DECRYPT_EN(1'b0)) dut0 (
        .g_clk(g_clk), .g_reset(g_reset), .key_valid(key_valid0), .key_ready(key_ready0),
        .key_in(key_in), .dec(dec), .flush(flush), .rk_valid(rk_valid0), .rk_ready(rk_ready),
        .rk(rk0), .rk_idx(rk_idx0), .rk_last(rk_last0)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box table built by walking generator 3 and its inverse together.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // Textbook 44-word key expansion.
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [127:0] k, input logic d);
        check("key_ready_before_accept", 128'(c_kready), 128'd1);
        key_in = k;
        dec = d;
        kv = 1'b1;
        @(negedge g_clk);
        kv = 1'b0;
    endtask

    task automatic emit_all(input logic dsc, input int stall, input bit fips);
        int got = 0;
        int budget = 0;
        int exp_idx;
        logic stalled = 1'b0;
        logic [127:0] prev_rk = '0;
        logic [3:0] prev_idx = '0;
        while (got < 11 && budget < 400) begin
            budget++;
            if (c_valid) begin
                if (stalled) begin
                    check("hold_rk", c_rk, prev_rk);
                    check("hold_idx", 128'(c_idx), 128'(prev_idx));
                end
                rk_ready = ($urandom_range(99) >= stall);
                if (rk_ready) begin
                    exp_idx = dsc ? 10 - got : got;
                    check("rk_idx", 128'(c_idx), 128'(exp_idx));
                    check("rk", c_rk, exp_rk[exp_idx]);
                    check("rk_last", 128'(c_last), 128'(got == 10));
                    if (fips && exp_idx == 1)  check("fips_rk1", c_rk, FIPS_RK1);
                    if (fips && exp_idx == 2)  check("fips_rk2", c_rk, FIPS_RK2);
                    if (fips && exp_idx == 10) check("fips_rk10", c_rk, FIPS_RK10);
                    if (fips && exp_idx == 0)  check("fips_rk0", c_rk, FIPS_KEY);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_rk = c_rk;
                    prev_idx = c_idx;
                end
            end else begin
                rk_ready = 1'($urandom_range(1));
                stalled = 1'b0;
            end
            @(negedge g_clk);
        end
        rk_ready = 1'b0;
        check("seq_complete", 128'(got), 128'd11);
        check("idle_key_ready", 128'(c_kready), 128'd1);
        check("idle_rk_valid", 128'(c_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] k;
        int n;
        build_sbox();

        // Reset state
        do_reset();
        check("reset_key_ready", 128'(c_kready), 128'd1);
        check("reset_rk_valid", 128'(c_valid), 128'd0);
        check("reset_rk", c_rk, 128'd0);
        check("reset_rk_idx", 128'(c_idx), 128'd0);
        check("reset_rk_last", 128'(c_last), 128'd0);

        // Encrypt, FIPS key, always ready
        expand(FIPS_KEY);
        rk_ready = 1'b1;
        accept(FIPS_KEY, 1'b0);
        check("enc_latency_valid", 128'(c_valid), 128'd1);
        check("enc_first_rk", c_rk, FIPS_KEY);
        emit_all(1'b0, 0, 1'b1);

        // Decrypt, FIPS key: rk10 appears on the 11th cycle after accept
        accept(FIPS_KEY, 1'b1);
        n = 1;
        while (!c_valid && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        check("dec_latency", 128'(n), 128'd11);
        check("dec_first_rk", c_rk, FIPS_RK10);
        emit_all(1'b1, 0, 1'b1);

        // Random keys with backpressure, both directions
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            accept(k, 1'b0);
            emit_all(1'b0, 40, 1'b0);
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            accept(k, 1'b1);
            emit_all(1'b1, 40, 1'b0);
        end

        // Flush in EMIT at round 5
        k = {$urandom, $urandom, $urandom, $urandom};
        rk_ready = 1'b1;
        accept(k, 1'b0);
        n = 0;
        while (!(c_valid && c_idx == 4'd5) && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        check("flush_emit_reach5", 128'(c_idx), 128'd5);
        flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        rk_ready = 1'b0;
        check("flush_emit_valid", 128'(c_valid), 128'd0);
        check("flush_emit_ready", 128'(c_kready), 128'd1);
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k, 1'b0);
        emit_all(1'b0, 30, 1'b0);

        // Flush during WIND
        accept({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (3) @(negedge g_clk);
        check("wind_not_valid", 128'(c_valid), 128'd0);
        check("wind_not_ready", 128'(c_kready), 128'd0);
        flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        check("flush_wind_valid", 128'(c_valid), 128'd0);
        check("flush_wind_ready", 128'(c_kready), 128'd1);
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k, 1'b1);
        emit_all(1'b1, 30, 1'b0);

        // Reset together with flush and a handshake mid-sequence
        rk_ready = 1'b1;
        accept(FIPS_KEY, 1'b0);
        repeat (3) @(negedge g_clk);
        check("pre_reset_valid", 128'(c_valid), 128'd1);
        g_reset = 1'b1;
        flush = 1'b1;
        kv = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge g_clk);
        g_reset = 1'b0;
        flush = 1'b0;
        kv = 1'b0;
        rk_ready = 1'b0;
        check("mid_reset_key_ready", 128'(c_kready), 128'd1);
        check("mid_reset_rk_valid", 128'(c_valid), 128'd0);
        check("mid_reset_rk", c_rk, 128'd0);
        check("mid_reset_rk_idx", 128'(c_idx), 128'd0);
        check("mid_reset_rk_last", 128'(c_last), 128'd0);

        // key_valid while busy is ignored
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k, 1'b1);
        key_in = ~k;
        kv = 1'b1;
        repeat (5) @(negedge g_clk);
        kv = 1'b0;
        emit_all(1'b1, 20, 1'b0);

        // DECRYPT_EN=0 instance ignores dec
        sel = 1'b1;
        do_reset();
        expand(FIPS_KEY);
        accept(FIPS_KEY, 1'b1);
        check("noenc_latency_valid", 128'(c_valid), 128'd1);
        emit_all(1'b0, 25, 1'b1);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
